// File: rtl/reg_bank_pkg.sv
// Shared types and register-map constants for the reg_bank register file.
package reg_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_STATUS = 1;
    localparam int unsigned FIRST_GP    = 2;

    // LOCK lives in the MSB of CTRL, so its index follows the data width.
    function automatic int unsigned lock_bit_idx(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/reg_bank_status.sv
// Sticky write-1-to-clear STATUS register; hardware set wins over a same-cycle clear.
module reg_bank_status #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] set_i,
    input  logic [DATA_W-1:0] clr_i,
    output logic [DATA_W-1:0] status_o,
    output logic              irq_c_o
);

    logic [DATA_W-1:0] status_d;
    logic [DATA_W-1:0] status_q;

    // Clear the written-1 bits, then OR in this cycle's events.
    always_comb begin
        status_d = (status_q & ~clr_i) | set_i;
    end

    // STATUS storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_o = status_q;
    assign irq_c_o  = |status_q;

endmodule

// File: rtl/reg_bank.sv
// DEPTH x DATA_W register bank behind a req/ack handshake with lock, range check and W1C status.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] hw_event_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

    localparam int unsigned LOCK_BIT = lock_bit_idx(DATA_W);
    localparam int unsigned GP_N     = DEPTH - FIRST_GP;
    localparam int unsigned GP_IW    = (GP_N > 1) ? $clog2(GP_N) : 1;

    // Reject parameter sets the register map cannot support.
    generate
        if (DATA_W < 2 || DEPTH < 3 || DEPTH > (2 ** ADDR_W)) begin : g_bad_param
            $error("reg_bank: need DATA_W >= 2 and 3 <= DEPTH <= 2**ADDR_W");
        end
    endgenerate

    state_e            state_d, state_q;
    logic              ready_d, ready_q;
    logic              ack_d, ack_q;
    logic              err_d, err_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic [DATA_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] gp_d [GP_N];
    logic [DATA_W-1:0] gp_q [GP_N];

    logic [DATA_W-1:0] clr_mask_c;
    logic [DATA_W-1:0] status_c;
    logic              irq_c;
    logic              addr_mapped_c;
    logic              is_ctrl_c;
    logic              is_status_c;
    logic [GP_IW-1:0]  gp_idx_c;
    logic [DATA_W-1:0] rd_val_c;

    // Full-width address decode; unmapped addresses never alias.
    always_comb begin
        addr_mapped_c = (32'(addr_i) < DEPTH);
        is_ctrl_c     = (addr_i == ADDR_W'(ADDR_CTRL));
        is_status_c   = (addr_i == ADDR_W'(ADDR_STATUS));
        gp_idx_c      = GP_IW'(addr_i - ADDR_W'(FIRST_GP));
        if (is_ctrl_c) begin
            rd_val_c = ctrl_q;
        end else if (is_status_c) begin
            rd_val_c = status_c;
        end else begin
            rd_val_c = gp_q[gp_idx_c];
        end
    end

    // Handshake FSM plus access execution at the accepting edge.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ctrl_d     = ctrl_q;
        gp_d       = gp_q;
        clr_mask_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_RESP;
                    ready_d = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (!addr_mapped_c) begin
                        err_d = 1'b1;
                    end else if (!wr_i) begin
                        rdata_d = rd_val_c;
                    end else if (is_status_c) begin
                        clr_mask_c = wdata_i;
                    end else if (ctrl_q[LOCK_BIT]) begin
                        err_d = 1'b1;
                    end else if (is_ctrl_c) begin
                        ctrl_d = wdata_i;
                    end else begin
                        gp_d[gp_idx_c] = wdata_i;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, response and register storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            gp_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            gp_q    <= gp_d;
        end
    end

    reg_bank_status #(
        .DATA_W(DATA_W)
    ) u_status (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .set_i   (hw_event_i),
        .clr_i   (clr_mask_c),
        .status_o(status_c),
        .irq_c_o (irq_c)
    );

    assign ready_o = ready_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign ctrl_o  = ctrl_q;
    assign irq_o   = irq_c;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized accesses against a map model.
module tb_reg_bank;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 7;
    localparam int unsigned DEP = 100;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          req_i = 1'b0;
    logic          wr_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic [DW-1:0] hw_event_i = '0;
    logic          ready_o, ack_o, err_o, irq_o;
    logic [DW-1:0] rdata_o, ctrl_o;

    int checks = 0;
    int failures = 0;

    // Register map model: index 0 = CTRL, 1 = STATUS, others general purpose.
    logic [7:0] mdl [DEP];

    reg_bank #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .wr_i(wr_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .hw_event_i(hw_event_i),
        .ready_o(ready_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .ctrl_o(ctrl_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic mdl_reset();
        foreach (mdl[i]) mdl[i] = 8'h00;
    endtask

    // Expected response of one accepted access, then the model's state after that edge.
    task automatic mdl_access(input bit wr, input int addr, input logic [7:0] wdata,
                              input logic [7:0] ev, output logic exp_err,
                              output logic [7:0] exp_rdata);
        logic [7:0] clr;
        clr = 8'h00;
        exp_err = 1'b0;
        exp_rdata = 8'h00;
        if (addr >= int'(DEP)) exp_err = 1'b1;
        else if (!wr) exp_rdata = mdl[addr];
        else if (addr == 1) clr = wdata;
        else if (mdl[0][7]) exp_err = 1'b1;
        else mdl[addr] = wdata;
        mdl[1] = (mdl[1] & ~clr) | ev;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        req_i = 1'b0;
        hw_event_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        mdl_reset();
    endtask

    // One access: samples the response cycle, the cycle after, and one more cycle.
    task automatic do_access(input bit wr, input int addr, input logic [7:0] wdata,
                             input logic [7:0] ev, input bit hold,
                             output logic ack1, output logic rdy1, output logic err,
                             output logic [7:0] rdata, output logic [7:0] ctrl,
                             output logic irq, output logic ack2, output logic rdy2,
                             output logic ack3);
        @(negedge clk_i);
        req_i = 1'b1;
        wr_i = wr;
        addr_i = 7'(addr);
        wdata_i = wdata;
        hw_event_i = ev;
        @(posedge clk_i);
        #1;
        ack1 = ack_o; rdy1 = ready_o; err = err_o; rdata = rdata_o; ctrl = ctrl_o; irq = irq_o;
        @(negedge clk_i);
        hw_event_i = '0;
        if (!hold) req_i = 1'b0;
        @(posedge clk_i);
        #1;
        ack2 = ack_o; rdy2 = ready_o;
        @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        ack3 = ack_o;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (rdata_o !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata_o); end
        checks++; if (ctrl_o !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", ctrl_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_read_after_reset();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_access(1'b0, 5, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL rd5_ack got=%b exp=1", a1); end
        checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL rd5_ready_resp got=%b exp=0", r1); end
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rd5_rdata got=%h exp=00", rd); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd5_err got=%b exp=0", e); end
        checks++; if (a2 !== 1'b0) begin failures++; $display("FAIL rd5_ack_len got=%b exp=0", a2); end
        checks++; if (r2 !== 1'b1) begin failures++; $display("FAIL rd5_ready_idle got=%b exp=1", r2); end
    endtask

    task automatic test_write_read();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_access(1'b1, 42, 8'h5A, 8'h00, 1'b1, a1, r1, e, rd, ct, ir, a2, r2, a3);
        mdl[42] = 8'h5A;
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr42_err got=%b exp=0", e); end
        checks++; if (a2 !== 1'b0) begin failures++; $display("FAIL wr42_hold_no_reaccept got=%b exp=0", a2); end
        do_access(1'b0, 42, 8'h00, 8'h00, 1'b1, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd42_rdata got=%h exp=5a", rd); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd42_err got=%b exp=0", e); end
        checks++; if (a2 !== 1'b0 || a3 !== 1'b0) begin failures++; $display("FAIL rd42_hold_no_reaccept got=%b%b exp=00", a2, a3); end
    endtask

    task automatic test_unmapped();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_access(1'b1, 99, 8'hC3, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        do_access(1'b1, 100, 8'hFF, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL wr100_err got err=%b rdata=%h exp err=1 rdata=00", e, rd); end
        do_access(1'b0, 127, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL rd127_err got err=%b rdata=%h exp err=1 rdata=00", e, rd); end
        do_access(1'b0, 99, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b0 || rd !== 8'hC3) begin failures++; $display("FAIL rd99_prior got err=%b rdata=%h exp err=0 rdata=c3", e, rd); end
        do_access(1'b0, 0, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rd0_no_alias got=%h exp=00", rd); end
    endtask

    task automatic test_lock();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_reset();
        do_access(1'b1, 0, 8'h80, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lock_set_err got=%b exp=0", e); end
        do_access(1'b1, 3, 8'h11, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL lock_wr3_err got=%b exp=1", e); end
        do_access(1'b1, 0, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL lock_wr0_err got=%b exp=1", e); end
        do_access(1'b0, 3, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL lock_rd3 got=%h exp=00", rd); end
        do_access(1'b0, 0, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h80) begin failures++; $display("FAIL lock_rd0 got=%h exp=80", rd); end
        checks++; if (ctrl_o !== 8'h80) begin failures++; $display("FAIL lock_ctrl_o got=%h exp=80", ctrl_o); end
        do_access(1'b1, 1, 8'hFF, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lock_status_wr_err got=%b exp=0", e); end
    endtask

    task automatic test_status();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_reset();
        @(negedge clk_i);
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_before got=%b exp=0", irq_o); end
        hw_event_i = 8'h05;
        @(posedge clk_i);
        #1;
        checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_after_event got=%b exp=1", irq_o); end
        @(negedge clk_i);
        hw_event_i = 8'h00;
        mdl[1] = 8'h05;
        do_access(1'b0, 1, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h05) begin failures++; $display("FAIL status_rd got=%h exp=05", rd); end
        do_access(1'b1, 1, 8'h01, 8'h01, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (e !== 1'b0 || rd !== 8'h00) begin failures++; $display("FAIL status_w1c_resp got err=%b rdata=%h exp err=0 rdata=00", e, rd); end
        do_access(1'b0, 1, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h05) begin failures++; $display("FAIL status_set_wins got=%h exp=05", rd); end
        do_access(1'b1, 1, 8'h05, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL status_irq_clear got=%b exp=0", ir); end
        do_access(1'b0, 1, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL status_cleared got=%h exp=00", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct;
        do_reset();
        @(negedge clk_i);
        req_i = 1'b1; wr_i = 1'b1; addr_i = 7'd7; wdata_i = 8'h33;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL rstresp_ack got=%b exp=0", ack_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rstresp_ready got=%b exp=1", ready_o); end
        @(negedge clk_i);
        req_i = 1'b0;
        rst_n_i = 1'b1;
        mdl_reset();
        do_access(1'b0, 7, 8'h00, 8'h00, 1'b0, a1, r1, e, rd, ct, ir, a2, r2, a3);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rstresp_rd7 got=%h exp=00", rd); end
    endtask

    task automatic test_random();
        logic a1, r1, e, ir, a2, r2, a3;
        logic [7:0] rd, ct, wd, ev, x_rd;
        logic x_err;
        bit wr;
        int addr;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            addr = int'($urandom_range(0, 127));
            wr = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            if (addr == 0) wd[7] = 1'b0;
            ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            mdl_access(wr, addr, wd, ev, x_err, x_rd);
            do_access(wr, addr, wd, ev, 1'($urandom_range(0, 1)), a1, r1, e, rd, ct, ir, a2, r2, a3);
            checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin failures++; $display("FAIL rnd%0d_ack got=%b%b exp=10", n, a1, a2); end
            checks++; if (e !== x_err) begin failures++; $display("FAIL rnd%0d_err addr=%0d wr=%b got=%b exp=%b", n, addr, wr, e, x_err); end
            if (!wr || x_err || addr == 1) begin
                checks++; if (rd !== x_rd) begin failures++; $display("FAIL rnd%0d_rdata addr=%0d got=%h exp=%h", n, addr, rd, x_rd); end
            end
            checks++; if (ct !== mdl[0]) begin failures++; $display("FAIL rnd%0d_ctrl got=%h exp=%h", n, ct, mdl[0]); end
            checks++; if (ir !== (mdl[1] != 8'h00)) begin failures++; $display("FAIL rnd%0d_irq got=%b exp=%b", n, ir, (mdl[1] != 8'h00)); end
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_unmapped();
        test_random();
        test_lock();
        test_status();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
